// File: rtl/weight_loader_if.sv
// Weight stream channel: valid/ready words with an end-of-layer marker.
// Master is the host/DMA side; slave is the loader.
interface weight_loader_if #(
  parameter int dataWidth = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [dataWidth-1:0] s_data;
  logic                 s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/weight_loader.sv
// Writes a neuron-major weight stream into a layer's per-neuron weight memories.
// Write latency 1 cycle; one word/cycle in LOAD; s_ready low outside LOAD.
module weight_loader #(
  parameter int numNeuron    = 10,
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  weight_loader_if.slave          s,
  output logic [numNeuron-1:0]    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NcW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [NcW-1:0]          NLAST = NcW'(numNeuron - 1);
  localparam logic [addressWidth-1:0] WLAST = addressWidth'(numWeight - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NcW-1:0]          ncnt_q, ncnt_d;
  logic [addressWidth-1:0] wcnt_q, wcnt_d;
  logic [numNeuron-1:0]    wen_q, wen_d;
  logic [addressWidth-1:0] wadd_q, wadd_d;
  logic [dataWidth-1:0]    win_q, win_d;
  logic                    error_q, error_d;

  logic accept;
  logic final_beat;
  logic term_beat;

  assign accept     = (state_q == LOAD) && s.s_valid;
  assign final_beat = (ncnt_q == NLAST) && (wcnt_q == WLAST);
  // s_last ends the load early; the final beat ends it regardless of s_last.
  assign term_beat  = accept && (final_beat || s.s_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ncnt_q  <= '0;
      wcnt_q  <= '0;
      wen_q   <= '0;
      wadd_q  <= '0;
      win_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ncnt_q  <= ncnt_d;
      wcnt_q  <= wcnt_d;
      wen_q   <= wen_d;
      wadd_q  <= wadd_d;
      win_q   <= win_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (term_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ncnt_d  = ncnt_q;
    wcnt_d  = wcnt_q;
    wen_d   = '0;
    wadd_d  = wadd_q;
    win_d   = win_q;
    error_d = error_q;
    if (state_q == IDLE && start) begin
      ncnt_d  = '0;
      wcnt_d  = '0;
      error_d = 1'b0;
    end
    if (accept) begin
      wen_d  = numNeuron'(1) << ncnt_q;
      wadd_d = wcnt_q;
      win_d  = s.s_data;
      if (final_beat != s.s_last) error_d = 1'b1;
      // Counters freeze on the terminating beat so they never wrap past the end.
      if (!term_beat) begin
        if (wcnt_q == WLAST) begin
          wcnt_d = '0;
          ncnt_d = ncnt_q + NcW'(1);
        end else begin
          wcnt_d = wcnt_q + addressWidth'(1);
        end
      end
    end
  end

  always_comb begin
    s.s_ready = (state_q == LOAD);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  assign wen   = wen_q;
  assign wadd  = wadd_q;
  assign win   = win_q;
  assign error = error_q;

endmodule
